// File: rtl/cnn_fmap_window_gen_pkg.sv
// Shared constants and types for the cnn_fmap_window_gen producer.
// CNN_* values are shared with cnn_core so producer and consumer agree on widths.
package cnn_fmap_window_gen_pkg;

    localparam int unsigned CNN_CI     = 1;
    localparam int unsigned CNN_KX     = 3;
    localparam int unsigned CNN_KY     = 3;
    localparam int unsigned CNN_I_F_BW = 8;
    localparam int unsigned CNN_WIN_BW = CNN_CI * CNN_KX * CNN_KY * CNN_I_F_BW;

    localparam int unsigned DEF_IMG_W = 28;
    localparam int unsigned DEF_IMG_H = 28;

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    // Bit offset of element (ci, ky, kx) inside a packed window.
    function automatic int elem_offset(input int ci, input int ky, input int kx,
                                       input int n_ky, input int n_kx, input int bw);
        return ((ci * n_ky + ky) * n_kx + kx) * bw;
    endfunction

endpackage

// File: rtl/cnn_fmap_window_gen_if.sv
// Pixel-in / window-out bundle of cnn_fmap_window_gen.
//   i_pix_valid, i_pix               : raster pixel stream (no backpressure)
//   o_win_valid, o_win_fmap          : one-cycle window strobe and packed window
//   o_frame_done                     : pulse with the last window of a frame
// slave = window generator side, master = pixel source / window consumer side.
interface cnn_fmap_window_gen_if
    import cnn_fmap_window_gen_pkg::*;
#(
    parameter int unsigned PIX_BW = CNN_CI * CNN_I_F_BW,
    parameter int unsigned WIN_BW = CNN_WIN_BW
) ();

    logic              i_pix_valid;
    logic [PIX_BW-1:0] i_pix;
    logic              o_win_valid;
    logic [WIN_BW-1:0] o_win_fmap;
    logic              o_frame_done;

    modport slave (
        input  i_pix_valid, i_pix,
        output o_win_valid, o_win_fmap, o_frame_done
    );

    modport master (
        output i_pix_valid, i_pix,
        input  o_win_valid, o_win_fmap, o_frame_done
    );

endinterface

// File: rtl/cnn_line_buffer.sv
// One image-row delay: DEPTH-deep shift register that advances only on en_i.
//   clk    : clock
//   en_i   : shift enable (accepted pixel)
//   din_i  : pixel entering the row delay
//   dout_o : pixel accepted DEPTH shifts ago (same column, previous row)
// Contents are never cleared; they are overwritten before being used.
module cnn_line_buffer #(
    parameter int unsigned DEPTH = 28,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             en_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[0] <= din_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign dout_o = mem_q[DEPTH-1];

endmodule

// File: rtl/cnn_fmap_window_gen.sv
// Sliding-window generator feeding cnn_core: raster pixels in, KX x KY x CI windows out
// (stride 1, no padding). One window strobe per accepted pixel whose window is complete.
//   clk          : clock
//   reset        : asynchronous, active-high
//   i_soft_reset : synchronous clear with the same effect as reset; wins over a pixel
//   bus          : pixel stream in, window / frame_done out (slave modport)
module cnn_fmap_window_gen
    import cnn_fmap_window_gen_pkg::*;
#(
    parameter int unsigned CI     = CNN_CI,
    parameter int unsigned KX     = CNN_KX,
    parameter int unsigned KY     = CNN_KY,
    parameter int unsigned I_F_BW = CNN_I_F_BW,
    parameter int unsigned IMG_W  = DEF_IMG_W,
    parameter int unsigned IMG_H  = DEF_IMG_H
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_soft_reset,
    cnn_fmap_window_gen_if.slave bus
);

    localparam int unsigned PIX_BW = CI * I_F_BW;
    localparam int unsigned WIN_BW = CI * KX * KY * I_F_BW;
    localparam int unsigned XW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned YW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [XW-1:0] X_LAST      = XW'(IMG_W - 1);
    localparam logic [XW-1:0] X_EMIT      = XW'(KX - 1);
    localparam logic [YW-1:0] Y_LAST      = YW'(IMG_H - 1);
    localparam logic [YW-1:0] Y_FILL_LAST = YW'(KY - 2);

    logic              accept, emit, last_pix;
    logic [XW-1:0]     x_cnt_q, x_cnt_d;
    logic [YW-1:0]     y_cnt_q, y_cnt_d;
    state_e            state_q, state_d;
    logic              valid_q, done_q;
    logic [WIN_BW-1:0] fmap_q, fmap_d;

    // chain[0] is the live pixel, chain[k+1] is the output of row delay k.
    logic [PIX_BW-1:0] chain [KY];
    logic [PIX_BW-1:0] win_q [KY][KX];
    logic [PIX_BW-1:0] win_d [KY][KX];

    // A pixel coinciding with soft reset is dropped.
    assign accept   = bus.i_pix_valid & ~i_soft_reset;
    assign last_pix = (x_cnt_q == X_LAST) && (y_cnt_q == Y_LAST);
    assign emit     = accept && (state_q == S_RUN) && (x_cnt_q >= X_EMIT);

    assign chain[0] = bus.i_pix;

    for (genvar k = 0; k < int'(KY) - 1; k++) begin : g_rows
        cnn_line_buffer #(
            .DEPTH (IMG_W),
            .WIDTH (PIX_BW)
        ) u_line (
            .clk    (clk),
            .en_i   (accept),
            .din_i  (chain[k]),
            .dout_o (chain[k+1])
        );
    end

    // Window shifts left one column per pixel; row r takes its new column from chain[KY-1-r],
    // so row KY-1 is the live row and row 0 the oldest.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < int'(KY); r++) begin
                for (int c = 0; c < int'(KX) - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][KX-1] = chain[KY-1-r];
            end
        end
    end

    always_comb begin
        fmap_d = '0;
        for (int ci = 0; ci < int'(CI); ci++) begin
            for (int ky = 0; ky < int'(KY); ky++) begin
                for (int kx = 0; kx < int'(KX); kx++) begin
                    fmap_d[elem_offset(ci, ky, kx, int'(KY), int'(KX), int'(I_F_BW)) +: I_F_BW] =
                        win_d[ky][kx][ci*I_F_BW +: I_F_BW];
                end
            end
        end
    end

    always_comb begin
        x_cnt_d = x_cnt_q;
        y_cnt_d = y_cnt_q;
        state_d = state_q;
        if (accept) begin
            if (x_cnt_q == X_LAST) begin
                x_cnt_d = '0;
                y_cnt_d = (y_cnt_q == Y_LAST) ? '0 : y_cnt_q + 1'b1;
            end else begin
                x_cnt_d = x_cnt_q + 1'b1;
            end
            case (state_q)
                S_FILL:  if (x_cnt_q == X_LAST && y_cnt_q == Y_FILL_LAST) state_d = S_RUN;
                S_RUN:   if (last_pix) state_d = S_FILL;
                default: state_d = S_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_cnt_q <= '0;
            y_cnt_q <= '0;
            state_q <= S_FILL;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            fmap_q  <= '0;
        end else if (i_soft_reset) begin
            x_cnt_q <= '0;
            y_cnt_q <= '0;
            state_q <= S_FILL;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            fmap_q  <= '0;
        end else begin
            x_cnt_q <= x_cnt_d;
            y_cnt_q <= y_cnt_d;
            state_q <= state_d;
            valid_q <= emit;
            done_q  <= emit & last_pix;
            if (emit) fmap_q <= fmap_d;
        end
    end

    // Window storage is data only; stale columns are never exposed, so no reset.
    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

    assign bus.o_win_valid  = valid_q;
    assign bus.o_frame_done = done_q;
    assign bus.o_win_fmap   = fmap_q;

endmodule

// File: tb/tb_cnn_fmap_window_gen.sv
// Bench for cnn_fmap_window_gen on a 5x5 frame, pixel = base + y*5 + x.
// dut1 has CI=1; dut2 has CI=2 with channel1 = channel0 + 50.
module tb_cnn_fmap_window_gen;

    localparam int W = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       soft_reset;
    logic       pix_valid;
    logic [7:0] pix;

    always #5 clk = ~clk;

    cnn_fmap_window_gen_if #(.PIX_BW(8),  .WIN_BW(72))  bus1 ();
    cnn_fmap_window_gen_if #(.PIX_BW(16), .WIN_BW(144)) bus2 ();

    assign bus1.i_pix_valid = pix_valid;
    assign bus1.i_pix       = pix;
    assign bus2.i_pix_valid = pix_valid;
    assign bus2.i_pix       = {pix + 8'd50, pix};

    cnn_fmap_window_gen #(
        .CI(1), .KX(3), .KY(3), .I_F_BW(8), .IMG_W(5), .IMG_H(5)
    ) dut1 (
        .clk          (clk),
        .reset        (reset),
        .i_soft_reset (soft_reset),
        .bus          (bus1)
    );

    cnn_fmap_window_gen #(
        .CI(2), .KX(3), .KY(3), .I_F_BW(8), .IMG_W(5), .IMG_H(5)
    ) dut2 (
        .clk          (clk),
        .reset        (reset),
        .i_soft_reset (soft_reset),
        .bus          (bus2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [71:0] fmap;
        logic        done;
    } win_t;

    typedef struct {
        logic [7:0]  pix;
        logic        exp_valid;
        logic        exp_done;
        logic [71:0] exp_fmap;
    } vec_t;

    win_t win_q[$];
    vec_t vecs[25];
    bit   mon_en     = 1'b0;
    bit   chk_narrow = 1'b0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [71:0] exp_win(input int base, input int x, input int y);
        logic [71:0] w;
        int          v;
        w = '0;
        for (int ky = 0; ky < 3; ky++) begin
            for (int kx = 0; kx < 3; kx++) begin
                v = base + (y - 2 + ky) * W + (x - 2 + kx);
                w[(ky*3+kx)*8 +: 8] = v[7:0];
            end
        end
        return w;
    endfunction

    always @(negedge clk) begin
        if (mon_en && bus1.o_win_valid) win_q.push_back('{bus1.o_win_fmap, bus1.o_frame_done});
        if (chk_narrow && bus1.o_win_valid) check("narrow_strobe", {143'd0, prev_valid}, 144'd0);
        prev_valid <= bus1.o_win_valid;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pix_valid = 1'b0;
        end
    endtask

    // mode 0: continuous; mode 1: gaps (random 0-4 in fill rows, toggle / 1-4 in run rows).
    task automatic send_frame(input int base, input int mode);
        int gap;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix       = 8'(base + i);
            gap = 0;
            if (mode == 1) begin
                if (i / W < 2)         gap = $urandom_range(0, 4);
                else if (i % 2 == 1)   gap = 1;
                else                   gap = $urandom_range(1, 4);
            end
            repeat (gap) begin
                @(negedge clk);
                pix_valid = 1'b0;
            end
        end
    endtask

    task automatic verify_frame(input string name, input int base, input int first);
        for (int k = 0; k < 9; k++) begin
            if (win_q.size() > first + k) begin
                check({name, "_win"}, {72'd0, win_q[first+k].fmap},
                      {72'd0, exp_win(base, 2 + k % 3, 2 + k / 3)});
                check({name, "_done"}, {143'd0, win_q[first+k].done}, {143'd0, (k == 8)});
            end else begin
                check({name, "_missing"}, 144'd0, 144'd1);
            end
        end
    endtask

    task automatic check_vec(input int i);
        check($sformatf("t1_valid[%0d]", i), {143'd0, bus1.o_win_valid}, {143'd0, vecs[i].exp_valid});
        check($sformatf("t1_done[%0d]", i), {143'd0, bus1.o_frame_done}, {143'd0, vecs[i].exp_done});
        check($sformatf("t1_fmap[%0d]", i), {72'd0, bus1.o_win_fmap}, {72'd0, vecs[i].exp_fmap});
    endtask

    initial begin
        logic [71:0] held;
        bit          em;

        held = '0;
        for (int i = 0; i < 25; i++) begin
            em = (i / W >= 2) && (i % W >= 2);
            if (em) held = exp_win(0, i % W, i / W);
            vecs[i].pix       = 8'(i);
            vecs[i].exp_valid = em;
            vecs[i].exp_done  = (i == 24);
            vecs[i].exp_fmap  = held;
        end

        reset = 1'b1; soft_reset = 1'b0; pix_valid = 1'b0; pix = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_valid", {143'd0, bus1.o_win_valid}, 144'd0);
        check("rst_done",  {143'd0, bus1.o_frame_done}, 144'd0);
        check("rst_fmap",  {72'd0, bus1.o_win_fmap}, 144'd0);
        check("rst_fmap2", bus2.o_win_fmap, 144'd0);
        reset = 1'b0;

        // Test 1 / 6: continuous frame, cycle-accurate table.
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (i > 0) check_vec(i - 1);
            if (i == 13) begin
                check("t1_first_lit", {72'd0, bus1.o_win_fmap}, {72'd0, 72'h0c0b0a_070605_020100});
                check("t6_first_ci2", bus2.o_win_fmap,
                      {72'h3e3d3c_393837_343332, 72'h0c0b0a_070605_020100});
            end
            pix_valid = 1'b1;
            pix       = vecs[i].pix;
        end
        @(negedge clk);
        check_vec(24);
        check("t1_last_lit", {72'd0, bus1.o_win_fmap}, {72'd0, 72'h181716_131211_0e0d0c});
        check("t6_last_ci2", bus2.o_win_fmap, {72'h4a4948_454443_403f3e, 72'h181716_131211_0e0d0c});
        pix_valid = 1'b0;
        @(negedge clk);
        check("t1_after_valid", {143'd0, bus1.o_win_valid}, 144'd0);

        // Test 2: gapped frame.
        win_q.delete();
        mon_en = 1'b1; chk_narrow = 1'b1;
        send_frame(0, 1);
        idle(4);
        chk_narrow = 1'b0;
        check("t2_count", 144'(win_q.size()), 144'd9);
        verify_frame("t2", 0, 0);

        // Test 3: back-to-back frames.
        win_q.delete();
        send_frame(0, 0);
        send_frame(100, 0);
        idle(3);
        check("t3_count", 144'(win_q.size()), 144'd18);
        verify_frame("t3a", 0, 0);
        verify_frame("t3b", 100, 9);
        if (win_q.size() > 9) check("t3_win10", {72'd0, win_q[9].fmap}, {72'd0, 72'h706f6e_6b6a69_666564});
        else check("t3_win10_missing", 144'd0, 144'd1);

        // Test 4: soft reset after pixel 17, with a pixel driven alongside.
        mon_en = 1'b0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix       = 8'(i);
        end
        @(negedge clk);
        soft_reset = 1'b1; pix_valid = 1'b1; pix = 8'd99;
        @(negedge clk);
        soft_reset = 1'b0; pix_valid = 1'b0;
        check("t4_srst_valid", {143'd0, bus1.o_win_valid}, 144'd0);
        check("t4_srst_fmap",  {72'd0, bus1.o_win_fmap}, 144'd0);
        win_q.delete();
        mon_en = 1'b1;
        send_frame(0, 0);
        idle(3);
        check("t4_count", 144'(win_q.size()), 144'd9);
        verify_frame("t4", 0, 0);

        // Test 5: async reset between clock edges mid-frame.
        mon_en = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix       = 8'(i);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        check("t5_pre_valid", {143'd0, bus1.o_win_valid}, 144'd1);
        #2 reset = 1'b1;
        #1;
        check("t5_arst_valid", {143'd0, bus1.o_win_valid}, 144'd0);
        check("t5_arst_fmap",  {72'd0, bus1.o_win_fmap}, 144'd0);
        check("t5_arst_done",  {143'd0, bus1.o_frame_done}, 144'd0);
        @(negedge clk);
        reset = 1'b0;
        win_q.delete();
        mon_en = 1'b1;
        send_frame(0, 0);
        idle(3);
        check("t5_count", 144'(win_q.size()), 144'd9);
        verify_frame("t5", 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
